mem_access: RTL and testbench



---
 rtl/mem_access.sv | 133 +++++++++++++
 tb/tb_mem_access.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: takes one settled ALU result, optionally performs a
// single data-memory load or store, and then presents a one-cycle writeback
// record. Misaligned loads/stores never reach memory and are flagged instead.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [31:0] in_rslt,
  input  logic [31:0] in_rrt,
  input  logic [4:0]  in_rd,
  input  logic        in_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_align,
  output logic [15:0] wait_cnt
);

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    WB
  } state_t;

  state_t      state;
  logic        is_lw_q;
  logic        we_q;
  logic [4:0]  rd_q;

  logic        accept;
  logic        is_mem;
  logic        aligned;

  // Ready only while idle; gating with rst_n keeps it low throughout reset
  // and lets it rise in the very first cycle after release.
  assign in_ready = (state == IDLE) && rst_n;
  assign accept   = in_valid && in_ready;
  assign is_mem   = (in_opcode == OP_LW) || (in_opcode == OP_SW);
  assign aligned  = (in_rslt[1:0] == 2'b00);

  // Main sequencer: all memory-port and writeback outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_lw_q    <= 1'b0;
      we_q       <= 1'b0;
      rd_q       <= 5'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 30'd0;
      dmem_wdata <= 32'd0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'd0;
      err_align  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rd_q    <= in_rd;
            we_q    <= in_we;
            is_lw_q <= (in_opcode == OP_LW);
            if (!is_mem) begin
              state    <= WB;
              wb_valid <= 1'b1;
              wb_we    <= in_we;
              wb_rd    <= in_rd;
              wb_data  <= in_rslt;
            end else if (aligned) begin
              state      <= MEM;
              dmem_req   <= 1'b1;
              dmem_we    <= (in_opcode == OP_SW);
              dmem_addr  <= in_rslt[31:2];
              dmem_wdata <= (in_opcode == OP_SW) ? in_rrt : 32'd0;
            end else begin
              state     <= WB;
              wb_valid  <= 1'b1;
              wb_we     <= 1'b0;
              wb_rd     <= in_rd;
              wb_data   <= 32'd0;
              err_align <= 1'b1;
            end
          end
        end
        MEM: begin
          if (dmem_ack) begin
            state      <= WB;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 30'd0;
            dmem_wdata <= 32'd0;
            wb_valid   <= 1'b1;
            wb_rd      <= rd_q;
            wb_we      <= is_lw_q ? we_q : 1'b0;
            wb_data    <= is_lw_q ? dmem_rdata : 32'd0;
          end
        end
        WB: begin
          state     <= IDLE;
          wb_valid  <= 1'b0;
          wb_we     <= 1'b0;
          wb_rd     <= 5'd0;
          wb_data   <= 32'd0;
          err_align <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of stalled memory cycles (request out, no ack yet).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 16'd0;
    end else if (dmem_req && !dmem_ack && (wait_cnt != 16'hFFFF)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a vector table of single operations plus
// hand-written sequences for reset, stray acks and wait-counter saturation.
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [31:0] in_rslt;
  logic [31:0] in_rrt;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_align;
  logic [15:0] wait_cnt;

  int          total;
  int          bad;
  logic [15:0] exp_wait;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rslt;
    logic [31:0] rrt;
    logic [4:0]  rd;
    logic        we;
    int          delay;
    logic [31:0] rdata;
    logic        exp_mem;
    logic        exp_dwe;
    logic [29:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_wbwe;
    logic [31:0] exp_wbdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  mem_access dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rslt    (in_rslt),
    .in_rrt     (in_rrt),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .err_align  (err_align),
    .wait_cnt   (wait_cnt)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic bumpWait();
    if (exp_wait != 16'hFFFF) exp_wait = 16'(exp_wait + 16'd1);
  endtask

  task automatic clearInputs();
    in_valid  = 1'b0;
    in_opcode = 6'd0;
    in_rslt   = 32'd0;
    in_rrt    = 32'd0;
    in_rd     = 5'd0;
    in_we     = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    checkOutput($sformatf("v%0d_ready_idle", idx), 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_opcode = v.op;
    in_rslt   = v.rslt;
    in_rrt    = v.rrt;
    in_rd     = v.rd;
    in_we     = v.we;
    @(posedge clk); #1;
    clearInputs();
    checkOutput($sformatf("v%0d_ready_busy", idx), 32'(in_ready), 32'd0);
    if (v.exp_mem) begin
      for (int w = 0; w <= v.delay; w++) begin
        checkOutput($sformatf("v%0d_req_c%0d", idx, w), 32'(dmem_req), 32'd1);
        checkOutput($sformatf("v%0d_addr_c%0d", idx, w), 32'(dmem_addr), 32'(v.exp_addr));
        checkOutput($sformatf("v%0d_dwe_c%0d", idx, w), 32'(dmem_we), 32'(v.exp_dwe));
        if (v.exp_dwe)
          checkOutput($sformatf("v%0d_wdata_c%0d", idx, w), dmem_wdata, v.exp_wdata);
        checkOutput($sformatf("v%0d_wbv_mem_c%0d", idx, w), 32'(wb_valid), 32'd0);
        if (w == v.delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = v.rdata;
        end else begin
          bumpWait();
        end
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
      end
    end else begin
      checkOutput($sformatf("v%0d_req_off", idx), 32'(dmem_req), 32'd0);
    end
    checkOutput($sformatf("v%0d_wb_valid", idx), 32'(wb_valid), 32'd1);
    checkOutput($sformatf("v%0d_wb_we", idx), 32'(wb_we), 32'(v.exp_wbwe));
    checkOutput($sformatf("v%0d_wb_data", idx), wb_data, v.exp_wbdata);
    if (!v.exp_err)
      checkOutput($sformatf("v%0d_wb_rd", idx), 32'(wb_rd), 32'(v.rd));
    checkOutput($sformatf("v%0d_err", idx), 32'(err_align), 32'(v.exp_err));
    checkOutput($sformatf("v%0d_req_wb", idx), 32'(dmem_req), 32'd0);
    checkOutput($sformatf("v%0d_ready_wb", idx), 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d_wbv_after", idx), 32'(wb_valid), 32'd0);
    checkOutput($sformatf("v%0d_err_after", idx), 32'(err_align), 32'd0);
    checkOutput($sformatf("v%0d_data_after", idx), wb_data, 32'd0);
    checkOutput($sformatf("v%0d_we_after", idx), 32'(wb_we), 32'd0);
    checkOutput($sformatf("v%0d_ready_after", idx), 32'(in_ready), 32'd1);
    checkOutput($sformatf("v%0d_wait_cnt", idx), 32'(wait_cnt), 32'(exp_wait));
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    exp_wait   = 16'd0;
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    clearInputs();

    //            op     rslt          rrt           rd  we dly rdata         mem dwe addr          wdata         wbwe wbdata        err
    vecs[0] = '{6'h00, 32'h12345678, 32'h0,        5'd3,  1, 0, 32'h0,        0, 0, 30'h0,        32'h0,        1, 32'h12345678, 0};
    vecs[1] = '{6'h23, 32'h00000100, 32'h0,        5'd5,  1, 3, 32'hDEADBEEF, 1, 0, 30'h40,       32'h0,        1, 32'hDEADBEEF, 0};
    vecs[2] = '{6'h2b, 32'h00000008, 32'hA5A5A5A5, 5'd7,  1, 0, 32'h0,        1, 1, 30'h2,        32'hA5A5A5A5, 0, 32'h0,        0};
    vecs[3] = '{6'h23, 32'h00000102, 32'h0,        5'd4,  1, 0, 32'h0,        0, 0, 30'h0,        32'h0,        0, 32'h0,        1};
    vecs[4] = '{6'h08, 32'hFFFF0000, 32'h0,        5'd31, 0, 0, 32'h0,        0, 0, 30'h0,        32'h0,        0, 32'hFFFF0000, 0};
    vecs[5] = '{6'h23, 32'hFFFFFFFC, 32'h0,        5'd1,  0, 1, 32'h0BADF00D, 1, 0, 30'h3FFFFFFF, 32'h0,        0, 32'h0BADF00D, 0};
    vecs[6] = '{6'h2b, 32'h00000201, 32'h11111111, 5'd6,  1, 0, 32'h0,        0, 0, 30'h0,        32'h0,        0, 32'h0,        1};
    vecs[7] = '{6'h23, 32'h00000004, 32'h0,        5'd2,  1, 0, 32'h00001234, 1, 0, 30'h1,        32'h0,        1, 32'h00001234, 0};

    // Reset state
    #2;
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_wbv", 32'(wb_valid), 32'd0);
    checkOutput("rst_err", 32'(err_align), 32'd0);
    checkOutput("rst_wait", 32'(wait_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("ready_after_release", 32'(in_ready), 32'd1);

    // Stray ack while idle must be ignored
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stray_wbv_c%0d", c), 32'(wb_valid), 32'd0);
      checkOutput($sformatf("stray_req_c%0d", c), 32'(dmem_req), 32'd0);
      checkOutput($sformatf("stray_ready_c%0d", c), 32'(in_ready), 32'd1);
    end
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    checkOutput("stray_wait", 32'(wait_cnt), 32'd0);

    // Vector table
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Reset in the second MEM cycle of a load
    in_valid  = 1'b1;
    in_opcode = 6'h23;
    in_rslt   = 32'h00000100;
    in_rd     = 5'd9;
    in_we     = 1'b1;
    @(posedge clk); #1;
    clearInputs();
    checkOutput("rmem_req_c0", 32'(dmem_req), 32'd1);
    bumpWait();
    @(posedge clk); #1;
    checkOutput("rmem_req_c1", 32'(dmem_req), 32'd1);
    checkOutput("rmem_wait_c1", 32'(wait_cnt), 32'(exp_wait));
    #2 rst_n = 1'b0;
    #1;
    exp_wait = 16'd0;
    checkOutput("rmem_req_async", 32'(dmem_req), 32'd0);
    checkOutput("rmem_ready_rst", 32'(in_ready), 32'd0);
    checkOutput("rmem_wait_rst", 32'(wait_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rmem_ready_release", 32'(in_ready), 32'd1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("rmem_late_wbv_c%0d", c), 32'(wb_valid), 32'd0);
      checkOutput($sformatf("rmem_late_req_c%0d", c), 32'(dmem_req), 32'd0);
    end
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;

    // Wait counter saturation on a long-stalled load
    in_valid  = 1'b1;
    in_opcode = 6'h23;
    in_rslt   = 32'h00000000;
    in_rd     = 5'd8;
    in_we     = 1'b1;
    @(posedge clk); #1;
    clearInputs();
    checkOutput("sat_start", 32'(wait_cnt), 32'd0);
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("sat_fffe", 32'(wait_cnt), 32'h0000FFFE);
    @(posedge clk); #1;
    checkOutput("sat_ffff", 32'(wait_cnt), 32'h0000FFFF);
    repeat (4465) @(posedge clk);
    #1;
    checkOutput("sat_hold", 32'(wait_cnt), 32'h0000FFFF);
    checkOutput("sat_req", 32'(dmem_req), 32'd1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    checkOutput("sat_wbv", 32'(wb_valid), 32'd1);
    checkOutput("sat_wbdata", wb_data, 32'h55AA55AA);
    checkOutput("sat_final", 32'(wait_cnt), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
